// File: rtl/bcd_clock_ctrl_pkg.sv
// Shared types, digit limits and helpers for the BCD wall-clock controller.
package bcd_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam logic [3:0] UNITS_MAX           = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX        = 4'd5;
  localparam logic [3:0] HOUR_TENS_MAX       = 4'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_2 = 4'd3;
  localparam logic [5:0] SEC_MAX             = 6'd59;

  localparam logic [3:0] COL_MIN_UNITS  = 4'b0001;
  localparam logic [3:0] COL_MIN_TENS   = 4'b0010;
  localparam logic [3:0] COL_HOUR_UNITS = 4'b0100;
  localparam logic [3:0] COL_HOUR_TENS  = 4'b1000;

  // Hours +1 modulo 24; returns {tens, units}.
  function automatic logic [7:0] hour_inc(input logic [3:0] tens, input logic [3:0] units);
    logic [3:0] t;
    logic [3:0] u;
    t = tens;
    u = units;
    if (tens == HOUR_TENS_MAX && units == HOUR_UNITS_MAX_AT_2) begin
      t = '0;
      u = '0;
    end else if (units == UNITS_MAX) begin
      t = tens + 4'd1;
      u = '0;
    end else begin
      u = units + 4'd1;
    end
    return {t, u};
  endfunction

  // Minutes +1 modulo 60; returns {carry_into_hours, tens, units}.
  function automatic logic [8:0] min_inc(input logic [3:0] tens, input logic [3:0] units);
    logic       c;
    logic [3:0] t;
    logic [3:0] u;
    c = 1'b0;
    t = tens;
    u = units;
    if (units == UNITS_MAX) begin
      u = '0;
      if (tens == MIN_TENS_MAX) begin
        t = '0;
        c = 1'b1;
      end else begin
        t = tens + 4'd1;
      end
    end else begin
      u = units + 4'd1;
    end
    return {c, t, u};
  endfunction

endpackage

// File: rtl/bcd_clock_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge press pulse.
module bcd_clock_ctrl_btn_debounce #(
  parameter int unsigned DEBOUNCE = 120000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    level_d = level_q;
    cnt_d   = '0;
    // Counts consecutive synchronised samples that disagree with the accepted level.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/bcd_clock_ctrl.sv
// 24 h BCD time-keeper with two-button set mode and a 4-column multiplexed digit display.
module bcd_clock_ctrl
  import bcd_clock_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12000000,
  parameter int unsigned SCAN_DIV = 12000,
  parameter int unsigned DEBOUNCE = 120000
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] col,
  output logic [3:0] row,
  output logic       sec_tick,
  output logic [1:0] mode
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [TickW-1:0] BlinkHalf = TickW'(TICK_DIV / 2);
  localparam logic [ScanW-1:0] ScanLast  = ScanW'(SCAN_DIV - 1);

  logic mode_press;
  logic inc_press;

  mode_e            mode_q, mode_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [TickW-1:0] blink_cnt_q, blink_cnt_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic             sec_tick_q, sec_tick_d;
  logic [5:0]       sec_q, sec_d;
  logic [3:0]       min_u_q, min_u_d;
  logic [3:0]       min_t_q, min_t_d;
  logic [3:0]       hr_u_q, hr_u_d;
  logic [3:0]       hr_t_q, hr_t_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       row_q, row_d;

  logic             min_carry;
  logic [3:0]       digit;
  logic             blank;

  bcd_clock_ctrl_btn_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_btn_debounce_mode (
    .clk_i  (hwclk),
    .rst_ni (rst_n),
    .btn_i  (btn_mode),
    .press_o(mode_press)
  );

  bcd_clock_ctrl_btn_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_btn_debounce_inc (
    .clk_i  (hwclk),
    .rst_ni (rst_n),
    .btn_i  (btn_inc),
    .press_o(inc_press)
  );

  // Mode FSM, tick divider and digit chain.
  always_comb begin
    mode_d     = mode_q;
    tick_cnt_d = '0;
    sec_tick_d = 1'b0;
    sec_d      = sec_q;
    min_u_d    = min_u_q;
    min_t_d    = min_t_q;
    hr_u_d     = hr_u_q;
    hr_t_d     = hr_t_q;
    min_carry  = 1'b0;

    if (mode_press) begin
      // A mode press wins over inc and over a coincident tick.
      unique case (mode_q)
        MODE_RUN: begin
          mode_d = MODE_SET_HR;
          sec_d  = '0;
        end
        MODE_SET_HR: mode_d = MODE_SET_MIN;
        default:     mode_d = MODE_RUN;
      endcase
    end else begin
      unique case (mode_q)
        MODE_RUN: begin
          if (tick_cnt_q == TickLast) begin
            sec_tick_d = 1'b1;
            if (sec_q == SEC_MAX) begin
              sec_d = '0;
              {min_carry, min_t_d, min_u_d} = min_inc(min_t_q, min_u_q);
              if (min_carry) begin
                {hr_t_d, hr_u_d} = hour_inc(hr_t_q, hr_u_q);
              end
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
        MODE_SET_HR: begin
          if (inc_press) begin
            {hr_t_d, hr_u_d} = hour_inc(hr_t_q, hr_u_q);
          end
        end
        default: begin
          // Carry out of minutes is deliberately dropped while setting.
          if (inc_press) begin
            {min_carry, min_t_d, min_u_d} = min_inc(min_t_q, min_u_q);
          end
        end
      endcase
    end
  end

  // Column scan, blink phase and registered row data.
  always_comb begin
    blink_cnt_d = (blink_cnt_q == TickLast) ? '0 : blink_cnt_q + TickW'(1);

    if (scan_cnt_q == ScanLast) begin
      scan_cnt_d = '0;
      col_d      = {col_q[2:0], col_q[3]};
    end else begin
      scan_cnt_d = scan_cnt_q + ScanW'(1);
      col_d      = col_q;
    end

    unique case (col_d)
      COL_MIN_UNITS:  digit = min_u_d;
      COL_MIN_TENS:   digit = min_t_d;
      COL_HOUR_UNITS: digit = hr_u_d;
      COL_HOUR_TENS:  digit = hr_t_d;
      default:        digit = hr_t_d;
    endcase

    // Row is built from next-state values so it always matches the column it is shown on.
    blank = (blink_cnt_d >= BlinkHalf) &&
            ((mode_d == MODE_SET_HR  && (col_d[2] || col_d[3])) ||
             (mode_d == MODE_SET_MIN && (col_d[0] || col_d[1])));
    row_d = blank ? 4'd0 : digit;
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_RUN;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      scan_cnt_q  <= '0;
      sec_tick_q  <= 1'b0;
      sec_q       <= '0;
      min_u_q     <= '0;
      min_t_q     <= '0;
      hr_u_q      <= '0;
      hr_t_q      <= '0;
      col_q       <= COL_MIN_UNITS;
      row_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      sec_tick_q  <= sec_tick_d;
      sec_q       <= sec_d;
      min_u_q     <= min_u_d;
      min_t_q     <= min_t_d;
      hr_u_q      <= hr_u_d;
      hr_t_q      <= hr_t_d;
      col_q       <= col_d;
      row_q       <= row_d;
    end
  end

  assign col      = col_q;
  assign row      = row_q;
  assign sec_tick = sec_tick_q;
  assign mode     = mode_q;

endmodule
